// File: rtl/regr_pipe.sv
// Multi-stage pipeline register with per-stage valid bits and a valid/ready handshake.
// Empty stages always accept (bubble collapsing); flush clears valids, hold freezes everything.
module regr_pipe #(
    parameter  int N     = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          hold,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] valid_reg;
    logic [N-1:0]     data_reg [DEPTH];
    logic [DEPTH:0]   ready_chain;
    logic [DEPTH-1:0] src_valid;
    logic [N-1:0]     src_data [DEPTH];
    logic             active;
    logic [CW-1:0]    count_sum;

    assign active         = !flush && !hold;
    assign ready_chain[DEPTH] = out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // A stage can take new data if it is empty or its occupant moves on.
            assign ready_chain[gi] = !valid_reg[gi] || ready_chain[gi+1];

            if (gi == 0) begin : g_src_in
                assign src_valid[gi] = in_valid && in_ready;
                assign src_data[gi]  = in_data;
            end else begin : g_src_prev
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_data[gi]  = data_reg[gi-1];
            end
        end
    endgenerate

    assign in_ready  = active && ready_chain[0];
    assign out_valid = active && valid_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_reg[k] <= '0;
            end
        end else if (flush) begin
            valid_reg <= '0;
        end else if (!hold) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (ready_chain[k]) begin
                    valid_reg[k] <= src_valid[k];
                    // Bubbles keep the old payload; only real data overwrites it.
                    if (src_valid[k]) begin
                        data_reg[k] <= src_data[k];
                    end
                end
            end
        end
    end

    always_comb begin
        count_sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_sum = count_sum + CW'(valid_reg[k]);
        end
    end

    assign count = count_sum;

endmodule

// File: tb/tb_regr_pipe.sv
// Scoreboard bench for regr_pipe: DEPTH=3 streaming/back-pressure/hold/flush/reset,
// plus a DEPTH=1 instance for the single-cycle latency case.
module tb_regr_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, hold, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  count;

    logic        in_valid1, out_ready1;
    logic [7:0]  in_data1;
    logic        in_ready1, out_valid1;
    logic [7:0]  out_data1;
    logic [0:0]  count1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] exp_q [$];

    bit lat_armed = 1'b0;
    bit acc_rec   = 1'b0;
    int acc_cyc   = 0;
    int lat_cyc   = 0;

    regr_pipe #(.N(32), .DEPTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    regr_pipe #(.N(8), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .hold(1'b0),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
        .count(count1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Inputs are set at the falling edge; acceptance is decided once they settle.
    task automatic step();
        #1;
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(in_data);
            $display("in  %08h (cycle %0d)", in_data, cyc);
            if (lat_armed && !acc_rec) begin
                acc_rec = 1'b1;
                acc_cyc = cyc;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever an output transfer is presented.
    always @(negedge clk) begin
        logic [31:0] want;
        #1;
        if (rst_n && lat_armed && acc_rec && out_valid) begin
            lat_cyc   = cyc;
            lat_armed = 1'b0;
        end
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got=%08h want=none", out_data);
            end else begin
                want = exp_q.pop_front();
                if (out_data !== want) begin
                    errors++;
                    $display("FAIL out_order got=%08h want=%08h", out_data, want);
                end else begin
                    $display("out %08h (cycle %0d)", out_data, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid1", 32'(out_valid1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stream 1..8 at full throughput.
        out_ready = 1'b1;
        lat_armed = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i + 1);
            #1;
            chk("stream_in_ready", 32'(in_ready), 1);
            if (i >= 3) chk("stream_count", 32'(count), 3);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("stream_latency", 32'(lat_cyc - acc_cyc), 3);
        chk("stream_drained", 32'(count), 0);
        chk("stream_empty_ov", 32'(out_valid), 0);

        // Back-pressure: fill three, stall, then release and finish 4 and 5.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h11 + 32'(i);
            #1;
            chk("bp_fill_ready", 32'(in_ready), 1);
            step();
        end
        in_data = 32'h14;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_full_in_ready", 32'(in_ready), 0);
            chk("bp_full_count", 32'(count), 3);
            chk("bp_full_ov", 32'(out_valid), 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_full_pass_ready", 32'(in_ready), 1);
        step();
        in_data = 32'h15;
        #1;
        chk("bp_count_same", 32'(count), 3);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("bp_drained", 32'(count), 0);

        // Alternating input: out_valid mirrors in_valid three cycles later.
        for (int j = 0; j < 12; j++) begin
            bit iv_now, iv_old;
            iv_now   = (j < 8) && (j % 2 == 0);
            iv_old   = (j >= 3) && ((j - 3) < 8) && ((j - 3) % 2 == 0);
            in_valid = iv_now;
            in_data  = 32'h21 + 32'(j / 2);
            #1;
            chk("alt_out_valid", 32'(out_valid), 32'(iv_old));
            chk("alt_count_le2", 32'(count <= 2), 1);
            step();
        end
        in_valid = 1'b0;

        // Hold with count=2 for four cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h31 + 32'(i);
            step();
        end
        hold = 1'b1; out_ready = 1'b1; in_data = 32'h33;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_out_valid", 32'(out_valid), 0);
            chk("hold_count", 32'(count), 2);
            step();
        end
        hold = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("hold_drained", 32'(count), 0);

        // Flush a full pipe while offering a word.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h41 + 32'(i);
            step();
        end
        chk("flush_pre_count", 32'(count), 3);
        flush = 1'b1; out_ready = 1'b1; in_data = 32'h44;
        #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        exp_q.delete();
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_count", 32'(count), 0);
        chk("flush_ov_after", 32'(out_valid), 0);
        in_valid = 1'b1; in_data = 32'h45;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Asynchronous reset mid-stream, between clock edges.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h51 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_count", 32'(count), 0);
        chk("areset_out_valid", 32'(out_valid), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // DEPTH=1 instance: single-cycle latency.
        in_valid1 = 1'b1; in_data1 = 8'hA5; out_ready1 = 1'b1;
        #1;
        chk("d1_in_ready", 32'(in_ready1), 1);
        chk("d1_ov_before", 32'(out_valid1), 0);
        @(negedge clk);
        in_valid1 = 1'b0;
        #1;
        chk("d1_out_valid", 32'(out_valid1), 1);
        chk("d1_out_data", 32'(out_data1), 32'hA5);
        chk("d1_count", 32'(count1), 1);
        @(negedge clk);
        #1;
        chk("d1_ov_after", 32'(out_valid1), 0);

        chk("sb_leftover", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
